mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared 4:1 32-bit datapath mux. Four requesters compete for one downstream valid/ready sink.
- The block registers the winning grant and drives the mux select. It forwards the selected requester's data with a valid/ready handshake.
- A granted requester keeps ownership for up to BURST_LEN accepted beats. Ownership then rotates.
- Used wherever several sources share one 32-bit bus into a single consumer in the core or its test harness.

---
 rtl/mux4_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and sequencer for a shared 4:1 data mux.
// Four requesters compete for one downstream valid/ready sink. The owner keeps
// the grant for up to BURST_LEN accepted beats, then ownership rotates.
//
// Handshake: a beat moves when valid_o && ready_i at a rising edge. valid_o
// mirrors the owner's request bit, so a withdrawing owner never transfers a
// beat. data_o is forced to zero whenever valid_o is low.
module mux4_rr_arbiter #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        req_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [DATA_W-1:0] data3_i,
    input  logic              ready_i,
    output logic [3:0]        grant_o,
    output logic [1:0]        sel_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              dbg_state_o,
    output logic [3:0]        dbg_beat_cnt_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_grant;
    logic [1:0]  r_sel;
    logic [1:0]  r_last;
    logic [3:0]  r_beat_cnt;

    logic              w_valid;
    logic              w_accept;
    logic              w_last_beat;
    logic              w_release;
    logic [1:0]        w_base;
    logic [1:0]        w_win;
    logic              w_found;
    logic [1:0]        w_scan;
    logic [DATA_W-1:0] w_mux;

    // Beat qualification and release detection for the current owner.
    always_comb begin
        w_valid     = (r_state == S_BUSY) && req_i[r_sel];
        w_accept    = w_valid && ready_i;
        w_last_beat = (r_beat_cnt == 4'(BURST_LEN - 1));
        w_release   = (r_state == S_BUSY) &&
                      (!req_i[r_sel] || (w_accept && w_last_beat));
    end

    // Round-robin scan: on a release the outgoing owner becomes the new
    // "last", so it is scanned last in the same-cycle re-arbitration.
    always_comb begin
        w_base  = (r_state == S_BUSY) ? r_sel : r_last;
        w_win   = w_base;
        w_found = 1'b0;
        w_scan  = w_base;
        for (int i = 1; i <= 4; i++) begin
            w_scan = w_base + 2'(i);
            if (!w_found && req_i[w_scan]) begin
                w_win   = w_scan;
                w_found = 1'b1;
            end
        end
    end

    // Data mux on the registered select.
    always_comb begin
        case (r_sel)
            2'd0:    w_mux = data0_i;
            2'd1:    w_mux = data1_i;
            2'd2:    w_mux = data2_i;
            default: w_mux = data3_i;
        endcase
    end

    // Grant FSM: IDLE picks a winner, BUSY counts beats and hands over on release.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_grant    <= 4'b0000;
            r_sel      <= 2'd0;
            r_last     <= 2'd3;
            r_beat_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_BUSY;
                        r_sel      <= w_win;
                        r_grant    <= 4'b0001 << w_win;
                        r_beat_cnt <= 4'd0;
                    end
                end
                default: begin
                    if (w_release) begin
                        r_last     <= r_sel;
                        r_beat_cnt <= 4'd0;
                        if (w_found) begin
                            r_sel   <= w_win;
                            r_grant <= 4'b0001 << w_win;
                        end else begin
                            r_state <= S_IDLE;
                            r_grant <= 4'b0000;
                        end
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Output drive; data is gated so idle or withdrawn cycles show zero.
    always_comb begin
        grant_o        = r_grant;
        sel_o          = r_sel;
        valid_o        = w_valid;
        data_o         = w_valid ? w_mux : '0;
        dbg_state_o    = r_state;
        dbg_beat_cnt_o = r_beat_cnt;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: one instance with BURST_LEN=4 and one with
// BURST_LEN=1 share the same inputs and are checked every cycle against an
// owner/count/last model, plus hand-computed checks at key points.
module tb_mux4_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        rdy;
  logic [31:0] dat [4];

  logic [3:0]  g [2];
  logic [1:0]  s [2];
  logic        v [2];
  logic [31:0] d [2];
  logic        st [2];
  logic [3:0]  bc [2];

  int n_cmp = 0;
  int n_bad = 0;

  // model state per instance: owner (-1 = idle), beat count, last owner
  int m_own [2];
  int m_cnt [2];
  int m_last [2];
  int m_bl [2] = '{4, 1};
  bit model_ok = 1'b0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DATA_W(32), .BURST_LEN(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .data0_i(dat[0]), .data1_i(dat[1]), .data2_i(dat[2]), .data3_i(dat[3]),
    .ready_i(rdy), .grant_o(g[0]), .sel_o(s[0]), .valid_o(v[0]), .data_o(d[0]),
    .dbg_state_o(st[0]), .dbg_beat_cnt_o(bc[0])
  );

  mux4_rr_arbiter #(.DATA_W(32), .BURST_LEN(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .data0_i(dat[0]), .data1_i(dat[1]), .data2_i(dat[2]), .data3_i(dat[3]),
    .ready_i(rdy), .grant_o(g[1]), .sel_o(s[1]), .valid_o(v[1]), .data_o(d[1]),
    .dbg_state_o(st[1]), .dbg_beat_cnt_o(bc[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int last, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  // model update on every rising edge
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_own[u] = -1; m_cnt[u] = 0; m_last[u] = 3;
        model_ok = 1'b1;
      end else if (m_own[u] < 0) begin
        if (req != 4'b0) begin
          m_own[u] = pick(m_last[u], req);
          m_cnt[u] = 0;
        end
      end else begin
        bit rel;
        rel = 1'b0;
        if (!req[m_own[u]]) rel = 1'b1;
        else if (rdy) begin
          if (m_cnt[u] == m_bl[u] - 1) rel = 1'b1;
          else m_cnt[u]++;
        end
        if (rel) begin
          m_last[u] = m_own[u];
          m_cnt[u] = 0;
          m_own[u] = (req != 4'b0) ? pick(m_last[u], req) : -1;
        end
      end
    end
  end

  // compare process: every falling edge once the model has seen reset
  always @(negedge clk) begin
    if (model_ok) begin
      for (int u = 0; u < 2; u++) begin
        logic [3:0]  eg;
        logic        ev;
        logic [31:0] ed;
        eg = (m_own[u] < 0) ? 4'b0 : (4'b0001 << m_own[u]);
        ev = (m_own[u] >= 0) && req[m_own[u]];
        ed = ev ? dat[m_own[u]] : 32'h0;
        chk($sformatf("u%0d.grant", u), 32'(g[u]), 32'(eg));
        chk($sformatf("u%0d.valid", u), 32'(v[u]), 32'(ev));
        chk($sformatf("u%0d.data", u), d[u], ed);
        chk($sformatf("u%0d.busy", u), 32'(st[u]), 32'(m_own[u] >= 0));
        if (m_own[u] >= 0) begin
          chk($sformatf("u%0d.sel", u), 32'(s[u]), 32'(m_own[u]));
          chk($sformatf("u%0d.beat_cnt", u), 32'(bc[u]), 32'(m_cnt[u]));
        end
      end
    end
  end

  // one cycle: drive just after the rising edge, then wait to the falling edge
  task automatic cyc(input logic r, input logic [3:0] q, input logic y);
    @(posedge clk);
    #1;
    rst = r; req = q; rdy = y;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] q);
    cyc(1'b1, q, 1'b1);
    cyc(1'b1, q, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req = 4'hF; rdy = 1'b0;
    dat[0] = 32'hA0A0_0000; dat[1] = 32'hB1B1_1111;
    dat[2] = 32'hDEAD_BEEF; dat[3] = 32'hC3C3_3333;

    // reset with all requests asserted
    cyc(1'b1, 4'hF, 1'b0);
    cyc(1'b1, 4'hF, 1'b0);
    for (int u = 0; u < 2; u++) begin
      chk("rst.grant", 32'(g[u]), 32'h0);
      chk("rst.sel", 32'(s[u]), 32'h0);
      chk("rst.valid", 32'(v[u]), 32'h0);
      chk("rst.data", d[u], 32'h0);
    end
    cyc(1'b0, 4'hF, 1'b1);
    cyc(1'b0, 4'hF, 1'b1);
    chk("post_rst.grant4", 32'(g[0]), 32'h1);
    chk("post_rst.grant1", 32'(g[1]), 32'h1);

    // single requester 2, burst of 4 then re-granted without a gap
    do_reset(4'b0100);
    cyc(1'b0, 4'b0100, 1'b1);
    cyc(1'b0, 4'b0100, 1'b1);
    chk("single.sel", 32'(s[0]), 32'd2);
    chk("single.grant", 32'(g[0]), 32'h4);
    chk("single.valid", 32'(v[0]), 32'h1);
    chk("single.data", d[0], 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100, 1'b1);
    chk("single.cnt3", 32'(bc[0]), 32'd3);
    cyc(1'b0, 4'b0100, 1'b1);
    chk("single.regrant", 32'(g[0]), 32'h4);
    chk("single.nogap", 32'(v[0]), 32'h1);
    chk("single.cnt0", 32'(bc[0]), 32'd0);

    // per-beat round robin on the BURST_LEN=1 instance
    do_reset(4'hF);
    cyc(1'b0, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'hF, 1'b1);
      chk($sformatf("rr.sel%0d", i), 32'(s[1]), 32'(i % 4));
      chk($sformatf("rr.valid%0d", i), 32'(v[1]), 32'h1);
    end

    // backpressure mid-burst on requester 1, requester 3 waiting
    do_reset(4'b0010);
    cyc(1'b0, 4'b0010, 1'b1);
    cyc(1'b0, 4'b1010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b1010, 1'b0);
      chk("bp.valid", 32'(v[0]), 32'h1);
      chk("bp.data", d[0], 32'hB1B1_1111);
      chk("bp.sel", 32'(s[0]), 32'd1);
      chk("bp.cnt", 32'(bc[0]), 32'd1);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1010, 1'b1);
    cyc(1'b0, 4'b1010, 1'b1);
    chk("bp.handover_sel", 32'(s[0]), 32'd3);
    chk("bp.handover_grant", 32'(g[0]), 32'h8);

    // withdrawal by requester 1
    do_reset(4'b0010);
    cyc(1'b0, 4'b0010, 1'b1);
    cyc(1'b0, 4'b1010, 1'b1);
    cyc(1'b0, 4'b1000, 1'b1);
    chk("wd.valid", 32'(v[0]), 32'h0);
    chk("wd.data", d[0], 32'h0);
    cyc(1'b0, 4'b1000, 1'b1);
    chk("wd.sel", 32'(s[0]), 32'd3);
    chk("wd.grant", 32'(g[0]), 32'h8);

    // reset during beat 2 of a requester-2 burst
    do_reset(4'b0100);
    cyc(1'b0, 4'b0100, 1'b1);
    cyc(1'b0, 4'b0100, 1'b1);
    cyc(1'b1, 4'b0100, 1'b1);
    chk("mr.cnt_before", 32'(bc[0]), 32'd1);
    cyc(1'b0, 4'b0101, 1'b1);
    chk("mr.grant_idle", 32'(g[0]), 32'h0);
    chk("mr.valid_idle", 32'(v[0]), 32'h0);
    cyc(1'b0, 4'b0101, 1'b1);
    chk("mr.winner", 32'(g[0]), 32'h1);
    chk("mr.sel", 32'(s[0]), 32'd0);

    // idle tail
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
